alu_pipe: RTL

Parametrised, registered execute unit for the backend. It computes RV32I/M integer results, branch conditions and branch targets behind a valid/ready handshake. Single-cycle ops and MUL/MULH* return one cycle after acceptance; DIV/REM run on an iterative divider. It sits between issue and writeback, one instance per integer execute port.

---
 rtl/lca_pkg.sv | 26 ++
 rtl/alu_divider.sv | 57 +++++
 rtl/alu_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lca_pkg.sv
// Shared types for the integer execute unit.
// Opcode set, FSM states and decode helpers.
package lca_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    LUI, AUIPC,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    MUL, MULH, MULHSU, MULHU,
    DIV, DIVU, REM, REMU
  } instr_opcode;

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } alu_state_t;

  function automatic logic is_branch(instr_opcode op);
    return op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
  endfunction

  function automatic logic is_div(instr_opcode op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// done is combinational in the final cycle; outputs valid with it.
module alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem_n;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    ge      = shifted >= {1'b0, dvs};
    rem_n   = ge ? shifted[XLEN-1:0] - dvs : shifted[XLEN-1:0];
  end

  assign quotient  = {quo[XLEN-2:0], ge};
  assign remainder = rem_n;
  assign done      = busy && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
    end else if (busy) begin
      quo <= quotient;
      rem <= rem_n;
      cnt <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered RV32I/M execute unit with valid/ready handshake.
// Define ALU_DIV_EN to build the iterative divider.
module alu_pipe
  import lca_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  instr_opcode      opcode,
  input  logic [XLEN-1:0]  src1_val,
  input  logic [XLEN-1:0]  src2_val,
  input  logic [XLEN-1:0]  imm_val,
  input  logic [XLEN-1:0]  pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  aluout,
  output logic             br_cond,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH = $clog2(XLEN);

  alu_state_t        state;
  logic              accept;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [XLEN-1:0]   res;
  logic [XLEN-1:0]   target;
  logic [SH-1:0]     shamt;
  logic              br;
  logic              ill;
  logic [2*XLEN-1:0] ea;
  logic [2*XLEN-1:0] eb;
  logic [2*XLEN-1:0] prod;

  assign a        = src1_val;
  assign b        = src2_val;
  assign shamt    = b[SH-1:0];
  assign target   = pc + imm_val;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready)
                    && !rst && !flush;
  assign accept   = in_valid && in_ready;

  // Low 2*XLEN bits of the extended product are exact for every MUL flavour
  always_comb begin
    ea   = {{XLEN{(opcode == MULH || opcode == MULHSU) && a[XLEN-1]}}, a};
    eb   = {{XLEN{(opcode == MULH) && b[XLEN-1]}}, b};
    prod = ea * eb;
  end

`ifdef ALU_DIV_EN
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  logic            dsgn;
  logic            drem;
  logic            dz;
  logic            dovf;
  logic            dstart;
  logic            ddone;
  logic            negq;
  logic            negr;
  logic            prem;
  logic [XLEN-1:0] amag;
  logic [XLEN-1:0] bmag;
  logic [XLEN-1:0] dq;
  logic [XLEN-1:0] dr;
  logic [XLEN-1:0] fq;
  logic [XLEN-1:0] fr;
  logic [XLEN-1:0] special;
  logic [TAG_W-1:0] ptag;

  assign dsgn    = opcode inside {DIV, REM};
  assign drem    = opcode inside {REM, REMU};
  assign dz      = (b == '0);
  assign dovf    = dsgn && (a == MINV) && (b == '1);
  assign special = dz ? (drem ? a : '1) : (drem ? '0 : a);
  assign amag    = (dsgn && a[XLEN-1]) ? -a : a;
  assign bmag    = (dsgn && b[XLEN-1]) ? -b : b;
  assign dstart  = accept && is_div(opcode) && !dz && !dovf;
  assign fq      = negq ? -dq : dq;
  assign fr      = negr ? -dr : dr;

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (dstart),
    .dividend  (amag),
    .divisor   (bmag),
    .done      (ddone),
    .quotient  (dq),
    .remainder (dr)
  );
`endif

  always_comb begin
    res = '0;
    br  = 1'b0;
    ill = 1'b0;
    case (opcode)
      ADD:    res = a + b;
      SUB:    res = a - b;
      SLL:    res = a << shamt;
      SLT:    res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      SLTU:   res = {{(XLEN-1){1'b0}}, a < b};
      XOR:    res = a ^ b;
      SRL:    res = a >> shamt;
      SRA:    res = $signed(a) >>> shamt;
      OR:     res = a | b;
      AND:    res = a & b;
      LUI:    res = imm_val;
      AUIPC:  res = target;
      BEQ:    begin res = target; br = (a == b); end
      BNE:    begin res = target; br = (a != b); end
      BLT:    begin res = target; br = $signed(a) < $signed(b); end
      BGE:    begin res = target; br = $signed(a) >= $signed(b); end
      BLTU:   begin res = target; br = a < b; end
      BGEU:   begin res = target; br = a >= b; end
      MUL:    res = prod[XLEN-1:0];
      MULH,
      MULHSU,
      MULHU:  res = prod[2*XLEN-1:XLEN];
`ifdef ALU_DIV_EN
      DIV,
      DIVU,
      REM,
      REMU:   res = special;
`endif
      default: ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      aluout      <= '0;
      br_cond     <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
`ifdef ALU_DIV_EN
        if (dstart) begin
          state <= DIV_BUSY;
          ptag  <= in_tag;
          negq  <= dsgn && (a[XLEN-1] ^ b[XLEN-1]);
          negr  <= dsgn && a[XLEN-1];
          prem  <= drem;
        end else
`endif
        begin
          out_valid   <= 1'b1;
          aluout      <= res;
          br_cond     <= br;
          out_illegal <= ill;
          out_tag     <= in_tag;
        end
      end
`ifdef ALU_DIV_EN
      if (state == DIV_BUSY && ddone) begin
        state       <= IDLE;
        out_valid   <= 1'b1;
        aluout      <= prem ? fr : fq;
        br_cond     <= 1'b0;
        out_illegal <= 1'b0;
        out_tag     <= ptag;
      end
`endif
    end
  end

endmodule
